multi_alarm_clock: RTL and testbench
====================================

// Module: multi_alarm_clock
// PURPOSE
//  24h HH:MM:SS timekeeper with NUM_ALARMS independent alarm channels.
//  Fully synchronous: prescaler produces a 1-cycle tick; no gated or divided clocks.
//  Sits under the board top; the top owns debouncing, switch mapping and 7-seg decode.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency; tick every CLK_HZ cycles
//  NUM_ALARMS  4           alarm channels (>=1)
//  RING_SEC    60          ringing auto-timeout, in ticks
//  SNOOZE_MIN  5           snooze delay, minutes (SNOOZE_EN only)
// PORTS
//  clk        in   1       system clock
//  reset_n    in   1       async, active-low reset
//  run        in   1       1 = time advances on tick
//  time_set   in   1       edit current time (time frozen)
//  alarm_set  in   1       edit alarm[alarm_sel] (time keeps running)
//  alarm_sel  in   AW      AW=$clog2(NUM_ALARMS) (min 1); channel to edit/display
//  set_hrs    in   1       1 = inc_pulse edits hours, 0 = minutes
//  inc_pulse  in   1       1-cycle, pre-debounced increment request
//  alarm_en   in   NUM_ALARMS  per-channel arm
//  ack        in   1       1-cycle; silences all ringing channels
//  snooze     in   1       1-cycle; snoozes ringing channels (ignored w/o SNOOZE_EN)
//  hrs/min/sec out 5/6/6   current time, binary
//  a_hrs/a_min out 5/6     stored time of alarm[alarm_sel]
//  alarm_active out NUM_ALARMS  channel ringing
//  alarm_out  out  1       |alarm_active
//  tick       out  1       1-cycle 1 Hz strobe (qualified by run & ~time_set)
// BEHAVIOUR
//  Reset: all outputs 0, time 00:00:00, all alarms 00:00, prescaler 0, channels IDLE.
//  Prescaler 0..CLK_HZ-1, counts only when run & ~time_set; held (not cleared) otherwise.
//  tick: sec 59->0 carries min; min 59->0 carries hrs; 23:59:59 -> 00:00:00.
//  Time registers update on the tick cycle.
//  time_set rising edge: sec and prescaler clear to 0.
//  While time_set: inc_pulse increments min (59->0) or hrs (23->0), no carry.
//  alarm_set & ~time_set: inc_pulse edits the selected alarm's min/hrs, same wrap rules.
//  time_set & alarm_set: time_set wins; alarm edit ignored.
//  Match = tick moved time to alarm HH:MM:00 and alarm_en[i].
//  Only ticks match; edits never trigger an alarm.
//  Channel FSM: IDLE -match-> RINGING (alarm_active[i]=1 the cycle after the tick).
//  RINGING -ack-> IDLE; RINGING -RING_SEC ticks-> IDLE.
//  RINGING -snooze-> SNOOZED; SNOOZED -tick reaching target HH:MM:00-> RINGING.
//  Any state with alarm_en[i]=0 -> IDLE next cycle; editing channel i in SNOOZED -> IDLE.
//  ack and match same cycle: ack clears prior ringers; newly matching channel rings.
//  ack & snooze same cycle: ack wins.
//  alarm_out is registered-equivalent: same cycle as alarm_active.
//  Reset mid-operation clears everything asynchronously; no alarm survives reset.
// CONFIGURATION
//  `MULTI_ALARM_SNOOZE_EN defined:
//   - snooze honoured; target = time at snooze + SNOOZE_MIN min (mod 24h, sec=00).
//  Undefined:
//   - snooze port present but ignored; SNOOZED state and target regs not built.
// STRUCTURE
//  clock_pkg: time_t struct {hrs[4:0],min[5:0],sec[5:0]}; alarm_state_e {IDLE,RINGING,SNOOZED};
//   constants MAX_SEC=59, MAX_MIN=59, MAX_HRS=23; function add_minutes(time_t,int).
//  Sub-module alarm_channel: per-channel alarm regs, FSM, timeout counter, snooze target;
//   generated NUM_ALARMS times.
//  Top holds prescaler, time counters, edit muxing.
// TESTING (CLK_HZ=4, NUM_ALARMS=2, RING_SEC=10, SNOOZE_MIN=5)
//  Rollover: time_set, set 23:59, release, 60 ticks -> 00:00:00 on 60th tick.
//  Alarm 0 = 00:01, en=1, run from 00:00:00 -> alarm_active=01 cycle after 00:01:00 tick;
//   ack -> 00 next cycle.
//  No ack -> alarm_active[0] drops after 10 ticks; alarm_en[0]=0 while ringing -> drops next cycle.
//  time_set & alarm_set & inc_pulse (set_hrs=0) -> min+1, alarm unchanged;
//   time frozen; sec=0.
//  SNOOZE_EN: ring at 00:01:00, snooze -> off, re-ring at 00:06:00.
//   Without macro: snooze no effect, still ringing.
//  reset_n low mid-ring, asynchronous to clk -> all outputs 0 before next edge;
//   alarms back to 00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time record, alarm channel states, calendar limits and minute arithmetic.
// Latency: none (types, constants and a pure function).
// Backpressure: not applicable.
package clock_pkg;

  typedef struct packed {
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_e;

  localparam int MAX_SEC = 59;
  localparam int MAX_MIN = 59;
  localparam int MAX_HRS = 23;

  // Advance a time of day by m minutes, wrapping at midnight; seconds forced to 00.
  function automatic time_t add_minutes(time_t t, int m);
    int    total;
    time_t r;
    total = (int'(t.hrs) * (MAX_MIN + 1) + int'(t.min) + m) % ((MAX_HRS + 1) * (MAX_MIN + 1));
    r.hrs = 5'(total / (MAX_MIN + 1));
    r.min = 6'(total % (MAX_MIN + 1));
    r.sec = '0;
    return r;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored HH:MM, ring FSM with tick-counted timeout, optional snooze (MULTI_ALARM_SNOOZE_EN).
// Latency: alarm_active rises on the edge that applies the matching tick; ack/disable clear on the next edge.
// Backpressure: none; all control inputs are single-cycle pulses or levels sampled every cycle.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       tick,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_min,
  input  logic [4:0] nxt_hrs,
  input  logic [5:0] nxt_min,
  input  logic [5:0] nxt_sec,
  input  logic       edit_inc,
  input  logic       edit_hrs,
  input  logic       ack,
  input  logic       snooze,
  output logic [4:0] a_hrs,
  output logic [5:0] a_min,
  output logic       active
);

  localparam int RW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  alarm_state_e  state;
  logic [RW-1:0] ring_cnt;
  logic          at_alarm;

  // A match only ever comes from a tick landing exactly on HH:MM:00.
  assign at_alarm = tick && (nxt_sec == 6'd0) && (nxt_hrs == a_hrs) && (nxt_min == a_min);

`ifdef MULTI_ALARM_SNOOZE_EN
  time_t target;
  time_t cur_t;
  logic  at_target;
  assign cur_t     = '{hrs: cur_hrs, min: cur_min, sec: 6'd0};
  assign at_target = tick && (nxt_sec == 6'd0) && (nxt_hrs == target.hrs) && (nxt_min == target.min);
`else
  localparam int unused_snooze_min = SNOOZE_MIN;
  logic unused_snooze;
  assign unused_snooze = ^{snooze, cur_hrs, cur_min};
`endif

  // Stored alarm time: increment hours or minutes, wrapping without carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_hrs <= '0;
      a_min <= '0;
    end else if (edit_inc) begin
      if (edit_hrs) a_hrs <= (a_hrs == 5'(MAX_HRS)) ? 5'd0 : a_hrs + 5'd1;
      else          a_min <= (a_min == 6'(MAX_MIN)) ? 6'd0 : a_min + 6'd1;
    end
  end

  // Ring FSM: disable beats everything, ack beats snooze, timeout counts ticks while ringing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ring_cnt <= '0;
      active   <= 1'b0;
`ifdef MULTI_ALARM_SNOOZE_EN
      target   <= '0;
`endif
    end else if (!en) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (at_alarm) begin
            state    <= RINGING;
            active   <= 1'b1;
            ring_cnt <= '0;
          end
        end
        RINGING: begin
          if (ack) begin
            state  <= IDLE;
            active <= 1'b0;
          end
`ifdef MULTI_ALARM_SNOOZE_EN
          else if (snooze) begin
            state  <= SNOOZED;
            active <= 1'b0;
            target <= add_minutes(cur_t, SNOOZE_MIN);
          end
`endif
          else if (tick) begin
            if (ring_cnt == RW'(RING_SEC - 1)) begin
              state  <= IDLE;
              active <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RW'(1);
            end
          end
        end
        SNOOZED: begin
`ifdef MULTI_ALARM_SNOOZE_EN
          if (edit_inc) begin
            state <= IDLE;
          end else if (at_target) begin
            state    <= RINGING;
            active   <= 1'b1;
            ring_cnt <= '0;
          end
`else
          state <= IDLE;
`endif
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24h HH:MM:SS timekeeper with NUM_ALARMS channels; snooze built only with MULTI_ALARM_SNOOZE_EN.
// Latency: time updates on the tick cycle edge; alarm_active/alarm_out follow one edge after the matching tick.
// Backpressure: none; inc_pulse/ack/snooze are single-cycle requests acted on in the cycle they arrive.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int AW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  time_set,
  input  logic                  alarm_set,
  input  logic [AW-1:0]         alarm_sel,
  input  logic                  set_hrs,
  input  logic                  inc_pulse,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  ack,
  input  logic                  snooze,
  output logic [4:0]            hrs,
  output logic [5:0]            min,
  output logic [5:0]            sec,
  output logic [4:0]            a_hrs,
  output logic [5:0]            a_min,
  output logic [NUM_ALARMS-1:0] alarm_active,
  output logic                  alarm_out,
  output logic                  tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc;
  time_t         cur;
  time_t         nxt;
  logic          time_set_q;
  logic          alarm_edit;
  logic [4:0]    ch_hrs [NUM_ALARMS];
  logic [5:0]    ch_min [NUM_ALARMS];

  assign tick       = run & ~time_set & (presc == PW'(CLK_HZ - 1));
  assign alarm_edit = alarm_set & ~time_set & inc_pulse;

  // Time one second ahead of now, carrying through minutes, hours and midnight.
  always_comb begin
    nxt = cur;
    if (cur.sec != 6'(MAX_SEC)) begin
      nxt.sec = cur.sec + 6'd1;
    end else begin
      nxt.sec = '0;
      if (cur.min != 6'(MAX_MIN)) begin
        nxt.min = cur.min + 6'd1;
      end else begin
        nxt.min = '0;
        nxt.hrs = (cur.hrs == 5'(MAX_HRS)) ? 5'd0 : cur.hrs + 5'd1;
      end
    end
  end

  // Prescaler and time of day: frozen and editable under time_set, else advancing on tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      cur        <= '0;
      time_set_q <= 1'b0;
    end else begin
      time_set_q <= time_set;
      if (time_set) begin
        if (!time_set_q) begin
          presc   <= '0;
          cur.sec <= '0;
        end
        if (inc_pulse) begin
          if (set_hrs) cur.hrs <= (cur.hrs == 5'(MAX_HRS)) ? 5'd0 : cur.hrs + 5'd1;
          else         cur.min <= (cur.min == 6'(MAX_MIN)) ? 6'd0 : cur.min + 6'd1;
        end
      end else if (run) begin
        if (tick) begin
          presc <= '0;
          cur   <= nxt;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (alarm_en[i]),
      .tick     (tick),
      .cur_hrs  (cur.hrs),
      .cur_min  (cur.min),
      .nxt_hrs  (nxt.hrs),
      .nxt_min  (nxt.min),
      .nxt_sec  (nxt.sec),
      .edit_inc (alarm_edit & (alarm_sel == AW'(i))),
      .edit_hrs (set_hrs),
      .ack      (ack),
      .snooze   (snooze),
      .a_hrs    (ch_hrs[i]),
      .a_min    (ch_min[i]),
      .active   (alarm_active[i])
    );
  end

  // Display the selected channel; an out-of-range select shows 00:00.
  always_comb begin
    a_hrs = '0;
    a_min = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (alarm_sel == AW'(i)) begin
        a_hrs = ch_hrs[i];
        a_min = ch_min[i];
      end
    end
  end

  assign hrs       = cur.hrs;
  assign min       = cur.min;
  assign sec       = cur.sec;
  assign alarm_out = |alarm_active;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: directed scenarios plus a randomized run against a reference model.
// Latency: checks sample on the falling edge, inputs change right after sampling.
// Backpressure: not applicable.
module tb_multi_alarm_clock;

  localparam int CLK_HZ = 4;
  localparam int NA     = 2;
  localparam int RSEC   = 10;
  localparam int SNZMIN = 5;
`ifdef MULTI_ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run, time_set, alarm_set, set_hrs, inc_pulse, ack, snooze;
  logic [0:0]    alarm_sel;
  logic [NA-1:0] alarm_en;
  logic [4:0]    hrs, a_hrs;
  logic [5:0]    min, sec, a_min;
  logic [NA-1:0] alarm_active;
  logic          alarm_out, tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_alarm_clock #(.CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .RING_SEC(RSEC), .SNOOZE_MIN(SNZMIN)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .time_set(time_set), .alarm_set(alarm_set),
    .alarm_sel(alarm_sel), .set_hrs(set_hrs), .inc_pulse(inc_pulse), .alarm_en(alarm_en),
    .ack(ack), .snooze(snooze), .hrs(hrs), .min(min), .sec(sec), .a_hrs(a_hrs), .a_min(a_min),
    .alarm_active(alarm_active), .alarm_out(alarm_out), .tick(tick)
  );

  task automatic clk_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    run = 0; time_set = 0; alarm_set = 0; alarm_sel = 0; set_hrs = 0;
    inc_pulse = 0; alarm_en = '0; ack = 0; snooze = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_inc();
    inc_pulse = 1'b1;
    clk_cycle();
    inc_pulse = 1'b0;
  endtask

  // Advance until n ticks have been applied, or give up after a cycle budget.
  task automatic run_ticks(input int n, output bit ok);
    int seen;
    int cyc;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < n * CLK_HZ * 2 + 8) begin
      if (tick) seen++;
      clk_cycle();
      cyc++;
    end
    ok = (seen == n);
  endtask

  // Advance until the displayed time equals h:m:s, or give up after budget cycles.
  task automatic wait_time(input int h, input int m, input int s, input int budget, output bit ok);
    int cyc;
    cyc = 0;
    while (!(int'(hrs) == h && int'(min) == m && int'(sec) == s) && cyc < budget) begin
      clk_cycle();
      cyc++;
    end
    ok = (int'(hrs) == h && int'(min) == m && int'(sec) == s);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({hrs, min, sec, a_hrs, a_min, alarm_active, alarm_out, tick} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: outputs=%h want 0", {hrs, min, sec, a_hrs, a_min, alarm_active, alarm_out, tick});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) clk_cycle();
    n_cmp++;
    if ({hrs, min, sec, a_hrs, a_min, alarm_active, alarm_out, tick} !== '0) begin
      n_err++;
      $display("FAIL reset_release: outputs=%h want 0", {hrs, min, sec, a_hrs, a_min, alarm_active, alarm_out, tick});
    end
  endtask

  task automatic test_rollover();
    bit ok;
    do_reset();
    time_set = 1'b1;
    set_hrs  = 1'b1;
    repeat (23) pulse_inc();
    set_hrs = 1'b0;
    repeat (59) pulse_inc();
    n_cmp++;
    if (hrs !== 5'd23 || min !== 6'd59 || sec !== 6'd0) begin
      n_err++;
      $display("FAIL rollover_set: got %0d:%0d:%0d want 23:59:0", hrs, min, sec);
    end
    time_set = 1'b0;
    run      = 1'b1;
    run_ticks(59, ok);
    n_cmp++;
    if (!ok || hrs !== 5'd23 || min !== 6'd59 || sec !== 6'd59) begin
      n_err++;
      $display("FAIL rollover_59: ok=%0d got %0d:%0d:%0d want 23:59:59", ok, hrs, min, sec);
    end
    run_ticks(1, ok);
    n_cmp++;
    if (!ok || hrs !== 5'd0 || min !== 6'd0 || sec !== 6'd0) begin
      n_err++;
      $display("FAIL rollover_60: ok=%0d got %0d:%0d:%0d want 0:0:0", ok, hrs, min, sec);
    end
  endtask

  task automatic test_alarm_ack();
    bit ok;
    do_reset();
    alarm_set = 1'b1;
    alarm_sel = 1'b0;
    pulse_inc();
    alarm_set = 1'b0;
    n_cmp++;
    if (a_hrs !== 5'd0 || a_min !== 6'd1) begin
      n_err++;
      $display("FAIL alarm_edit: got %0d:%0d want 0:1", a_hrs, a_min);
    end
    alarm_en = 2'b01;
    run      = 1'b1;
    run_ticks(59, ok);
    n_cmp++;
    if (!ok || sec !== 6'd59 || alarm_active !== 2'b00) begin
      n_err++;
      $display("FAIL alarm_early: ok=%0d sec=%0d active=%b want 59/00", ok, sec, alarm_active);
    end
    run_ticks(1, ok);
    n_cmp++;
    if (!ok || min !== 6'd1 || sec !== 6'd0 || alarm_active !== 2'b01 || alarm_out !== 1'b1) begin
      n_err++;
      $display("FAIL alarm_ring: ok=%0d time=%0d:%0d active=%b out=%b want 1:0/01/1", ok, min, sec, alarm_active, alarm_out);
    end
    ack = 1'b1;
    clk_cycle();
    ack = 1'b0;
    n_cmp++;
    if (alarm_active !== 2'b00 || alarm_out !== 1'b0) begin
      n_err++;
      $display("FAIL alarm_ack: active=%b out=%b want 00/0", alarm_active, alarm_out);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    alarm_set = 1'b1;
    pulse_inc();
    alarm_set = 1'b0;
    wait_time(0, 2, 0, 400, ok);
    n_cmp++;
    if (!ok || alarm_active !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_ring: ok=%0d active=%b want 01", ok, alarm_active);
    end
    run_ticks(RSEC - 1, ok);
    n_cmp++;
    if (!ok || alarm_active !== 2'b01) begin
      n_err++;
      $display("FAIL timeout_9: ok=%0d active=%b want 01", ok, alarm_active);
    end
    run_ticks(1, ok);
    n_cmp++;
    if (!ok || alarm_active !== 2'b00) begin
      n_err++;
      $display("FAIL timeout_10: ok=%0d active=%b want 00", ok, alarm_active);
    end
    alarm_set = 1'b1;
    pulse_inc();
    alarm_set = 1'b0;
    wait_time(0, 3, 0, 400, ok);
    n_cmp++;
    if (!ok || alarm_active !== 2'b01) begin
      n_err++;
      $display("FAIL disable_ring: ok=%0d active=%b want 01", ok, alarm_active);
    end
    alarm_en = 2'b00;
    clk_cycle();
    n_cmp++;
    if (alarm_active !== 2'b00 || alarm_out !== 1'b0) begin
      n_err++;
      $display("FAIL disable_drop: active=%b out=%b want 00/0", alarm_active, alarm_out);
    end
    alarm_en = 2'b01;
  endtask

  task automatic test_edit_priority();
    bit ok;
    int ticks_seen;
    do_reset();
    run = 1'b1;
    run_ticks(7, ok);
    n_cmp++;
    if (!ok || sec !== 6'd7) begin
      n_err++;
      $display("FAIL edit_pre: ok=%0d sec=%0d want 7", ok, sec);
    end
    time_set  = 1'b1;
    alarm_set = 1'b1;
    alarm_sel = 1'b1;
    set_hrs   = 1'b0;
    pulse_inc();
    n_cmp++;
    if (hrs !== 5'd0 || min !== 6'd1 || sec !== 6'd0 || a_hrs !== 5'd0 || a_min !== 6'd0) begin
      n_err++;
      $display("FAIL edit_both: time=%0d:%0d:%0d alarm=%0d:%0d want 0:1:0 / 0:0", hrs, min, sec, a_hrs, a_min);
    end
    set_hrs = 1'b1;
    repeat (23) pulse_inc();
    n_cmp++;
    if (hrs !== 5'd23) begin
      n_err++;
      $display("FAIL edit_hrs23: hrs=%0d want 23", hrs);
    end
    pulse_inc();
    n_cmp++;
    if (hrs !== 5'd0 || a_hrs !== 5'd0) begin
      n_err++;
      $display("FAIL edit_hrs_wrap: hrs=%0d a_hrs=%0d want 0/0", hrs, a_hrs);
    end
    ticks_seen = 0;
    repeat (12) begin
      if (tick) ticks_seen++;
      clk_cycle();
    end
    n_cmp++;
    if (ticks_seen != 0 || min !== 6'd1 || sec !== 6'd0) begin
      n_err++;
      $display("FAIL edit_frozen: ticks=%0d time=%0d:%0d want 0 ticks, 1:0", ticks_seen, min, sec);
    end
    time_set = 1'b0;
    run      = 1'b0;
    set_hrs  = 1'b0;
    repeat (61) pulse_inc();
    set_hrs = 1'b1;
    repeat (25) pulse_inc();
    alarm_set = 1'b0;
    n_cmp++;
    if (a_hrs !== 5'd1 || a_min !== 6'd1) begin
      n_err++;
      $display("FAIL alarm_wrap: got %0d:%0d want 1:1", a_hrs, a_min);
    end
    alarm_sel = 1'b0;
    clk_cycle();
    n_cmp++;
    if (a_hrs !== 5'd0 || a_min !== 6'd0) begin
      n_err++;
      $display("FAIL alarm_sel0: got %0d:%0d want 0:0", a_hrs, a_min);
    end
  endtask

  task automatic test_snooze();
    bit ok;
    do_reset();
    alarm_set = 1'b1;
    pulse_inc();
    alarm_set = 1'b0;
    alarm_en  = 2'b01;
    run       = 1'b1;
    wait_time(0, 1, 0, 400, ok);
    n_cmp++;
    if (!ok || alarm_active !== 2'b01) begin
      n_err++;
      $display("FAIL snooze_ring1: ok=%0d active=%b want 01", ok, alarm_active);
    end
    snooze = 1'b1;
    clk_cycle();
    snooze = 1'b0;
    n_cmp++;
    if (alarm_active !== (SNZ ? 2'b00 : 2'b01)) begin
      n_err++;
      $display("FAIL snooze_press: active=%b want %b", alarm_active, SNZ ? 2'b00 : 2'b01);
    end
    if (SNZ) begin
      wait_time(0, 5, 59, 1400, ok);
      n_cmp++;
      if (!ok || alarm_active !== 2'b00) begin
        n_err++;
        $display("FAIL snooze_quiet: ok=%0d active=%b want 00", ok, alarm_active);
      end
      wait_time(0, 6, 0, 20, ok);
      n_cmp++;
      if (!ok || alarm_active !== 2'b01) begin
        n_err++;
        $display("FAIL snooze_rering: ok=%0d active=%b want 01", ok, alarm_active);
      end
    end
    ack = 1'b1;
    clk_cycle();
    ack = 1'b0;
    n_cmp++;
    if (alarm_active !== 2'b00) begin
      n_err++;
      $display("FAIL snooze_ack: active=%b want 00", alarm_active);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    alarm_set = 1'b1;
    pulse_inc();
    alarm_sel = 1'b1;
    pulse_inc();
    alarm_sel = 1'b0;
    alarm_set = 1'b0;
    alarm_en  = 2'b11;
    run       = 1'b1;
    wait_time(0, 1, 0, 400, ok);
    n_cmp++;
    if (!ok || alarm_active !== 2'b11) begin
      n_err++;
      $display("FAIL areset_ring: ok=%0d active=%b want 11", ok, alarm_active);
    end
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({hrs, min, sec, a_hrs, a_min, alarm_active, alarm_out, tick} !== '0) begin
      n_err++;
      $display("FAIL areset_now: outputs=%h want 0", {hrs, min, sec, a_hrs, a_min, alarm_active, alarm_out, tick});
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_ticks(3, ok);
    alarm_sel = 1'b1;
    clk_cycle();
    n_cmp++;
    if (!ok || a_hrs !== 5'd0 || a_min !== 6'd0 || alarm_active !== 2'b00 || sec !== 6'd3) begin
      n_err++;
      $display("FAIL areset_after: ok=%0d alarm1=%0d:%0d active=%b sec=%0d want 0:0/00/3", ok, a_hrs, a_min, alarm_active, sec);
    end
  endtask

  // Randomized run; the model keeps time as seconds-of-day and alarms as minutes-of-day.
  task automatic test_random();
    int  m_t, m_presc, h, mi, s, nt;
    bit  m_tsq, tk, edit, ts_state;
    int  m_am  [NA];
    int  m_st  [NA];
    int  m_rc  [NA];
    int  m_tgt [NA];
    bit  exp_any;
    do_reset();
    m_t = 0; m_presc = 0; m_tsq = 0; ts_state = 0;
    for (int c = 0; c < NA; c++) begin
      m_am[c] = 0; m_st[c] = 0; m_rc[c] = 0; m_tgt[c] = 0;
    end
    alarm_en = 2'b11;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      n_cmp++;
      if (int'(hrs) != m_t / 3600 || int'(min) != (m_t / 60) % 60 || int'(sec) != m_t % 60) begin
        n_err++;
        $display("FAIL rnd_time cyc%0d: got %0d:%0d:%0d want %0d:%0d:%0d", cyc, hrs, min, sec,
                 m_t / 3600, (m_t / 60) % 60, m_t % 60);
      end
      n_cmp++;
      if (int'(a_hrs) != m_am[alarm_sel] / 60 || int'(a_min) != m_am[alarm_sel] % 60) begin
        n_err++;
        $display("FAIL rnd_alarm cyc%0d: got %0d:%0d want %0d:%0d", cyc, a_hrs, a_min,
                 m_am[alarm_sel] / 60, m_am[alarm_sel] % 60);
      end
      n_cmp++;
      tk = run && !time_set && (m_presc == CLK_HZ - 1);
      if (tick !== tk) begin
        n_err++;
        $display("FAIL rnd_tick cyc%0d: got %b want %b", cyc, tick, tk);
      end
      exp_any = 1'b0;
      for (int c = 0; c < NA; c++) begin
        exp_any |= (m_st[c] == 1);
        n_cmp++;
        if (alarm_active[c] !== (m_st[c] == 1)) begin
          n_err++;
          $display("FAIL rnd_active%0d cyc%0d: got %b want %b", c, cyc, alarm_active[c], m_st[c] == 1);
        end
      end
      n_cmp++;
      if (alarm_out !== exp_any) begin
        n_err++;
        $display("FAIL rnd_out cyc%0d: got %b want %b", cyc, alarm_out, exp_any);
      end
      // new stimulus
      if ($urandom_range(0, 199) == 0) ts_state = ~ts_state;
      time_set  = ts_state;
      run       = ($urandom_range(0, 15) != 0);
      alarm_set = ($urandom_range(0, 7) == 0);
      alarm_sel = 1'($urandom_range(0, 1));
      set_hrs   = ($urandom_range(0, 3) == 0);
      inc_pulse = ($urandom_range(0, 63) == 0);
      ack       = ($urandom_range(0, 31) == 0);
      snooze    = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 149) == 0) alarm_en[0] = ~alarm_en[0];
      if ($urandom_range(0, 149) == 0) alarm_en[1] = ~alarm_en[1];
      @(posedge clk);
      // reference model step for this edge
      tk = run && !time_set && (m_presc == CLK_HZ - 1);
      nt = m_t;
      if (time_set) begin
        if (!m_tsq) begin
          nt      = nt - nt % 60;
          m_presc = 0;
        end
        if (inc_pulse) begin
          h = nt / 3600; mi = (nt / 60) % 60; s = nt % 60;
          if (set_hrs) h = (h + 1) % 24;
          else         mi = (mi + 1) % 60;
          nt = h * 3600 + mi * 60 + s;
        end
      end else if (run) begin
        if (tk) begin
          m_presc = 0;
          nt      = (m_t + 1) % 86400;
        end else begin
          m_presc++;
        end
      end
      for (int c = 0; c < NA; c++) begin
        edit = alarm_set && !time_set && inc_pulse && (int'(alarm_sel) == c);
        if (!alarm_en[c]) begin
          m_st[c] = 0;
        end else if (m_st[c] == 0) begin
          if (tk && nt == m_am[c] * 60) begin m_st[c] = 1; m_rc[c] = 0; end
        end else if (m_st[c] == 1) begin
          if (ack) m_st[c] = 0;
          else if (SNZ && snooze) begin
            m_st[c]  = 2;
            m_tgt[c] = (m_t / 60 + SNZMIN) % 1440;
          end else if (tk) begin
            m_rc[c]++;
            if (m_rc[c] == RSEC) m_st[c] = 0;
          end
        end else begin
          if (edit) m_st[c] = 0;
          else if (tk && nt == m_tgt[c] * 60) begin m_st[c] = 1; m_rc[c] = 0; end
        end
        if (edit) begin
          if (set_hrs) m_am[c] = ((m_am[c] / 60 + 1) % 24) * 60 + m_am[c] % 60;
          else         m_am[c] = (m_am[c] / 60) * 60 + (m_am[c] % 60 + 1) % 60;
        end
      end
      m_t   = nt;
      m_tsq = time_set;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_rollover();
    test_alarm_ack();
    test_timeout();
    test_edit_priority();
    test_snooze();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
